// File: rtl/cla_serial_adder16_if.sv
// cla_serial_adder16_if -- operand/result bundle for the nibble-serial adder.
// The sub line exists only when CLA_SERIAL_SUB_EN is defined.
`default_nettype none

interface cla_serial_adder16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef CLA_SERIAL_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef CLA_SERIAL_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/cla_serial_adder16.sv
// cla_serial_adder16 -- nibble-serial adder driving one 4-bit CLA block, WIDTH/4 cycles per add.
// Define CLA_SERIAL_SUB_EN to add the sub input (a - b). Rev 1.0
`default_nettype none

module cla_serial_adder16_cla4 (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       cin,
  output logic      [3:0] sum,
  output logic            cout,
  output logic            grp_p,
  output logic            grp_g
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign sum  = p ^ c;
  assign cout = grp_g | (grp_p & cin);
endmodule

module cla_serial_adder16 #(
  parameter int WIDTH = 16
) (
  input wire logic              clk,
  input wire logic              rst,
  cla_serial_adder16_if.slave   bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_rc;
  logic [WIDTH-1:0] r_ps;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [IDXW+1:0]  w_off;
  logic [3:0]       w_nib_sum;
  logic             w_nib_cout;
  logic [WIDTH-1:0] w_ps_next;
  logic [WIDTH-1:0] w_rb_load;
  logic             w_rc_load;

  // Accepted in IDLE and DONE alike, so a held start chains operations.
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_off    = {r_idx, 2'b00};

`ifdef CLA_SERIAL_SUB_EN
  assign w_rb_load = bus.sub ? ~bus.b : bus.b;
  assign w_rc_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_rb_load = bus.b;
  assign w_rc_load = bus.cin;
`endif

  cla_serial_adder16_cla4 u_cla4 (
    .a     (r_ra[w_off +: 4]),
    .b     (r_rb[w_off +: 4]),
    .cin   (r_rc),
    .sum   (w_nib_sum),
    .cout  (w_nib_cout),
    .grp_p (),
    .grp_g ()
  );

  always_comb begin
    w_ps_next              = r_ps;
    w_ps_next[w_off +: 4]  = w_nib_sum;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_ra   <= '0;
      r_rb   <= '0;
      r_rc   <= 1'b0;
      r_ps   <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_ra  <= bus.a;
      r_rb  <= w_rb_load;
      r_rc  <= w_rc_load;
      r_idx <= '0;
      r_ps  <= '0;
    end else if (r_state == S_RUN) begin
      r_ps <= w_ps_next;
      r_rc <= w_nib_cout;
      if (w_last) begin
        r_sum  <= w_ps_next;
        r_cout <= w_nib_cout;
        r_ovf  <= (r_ra[WIDTH-1] == r_rb[WIDTH-1]) && (w_ps_next[WIDTH-1] != r_ra[WIDTH-1]);
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_cla_serial_adder16.sv
// tb_cla_serial_adder16 -- directed vector table plus handshake/reset sequences.
`default_nettype none

module tb_cla_serial_adder16;
  logic clk = 1'b0;
  logic rst;

  cla_serial_adder16_if #(.WIDTH(16)) bus ();

  cla_serial_adder16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] prev_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef CLA_SERIAL_SUB_EN
    bus.sub = sub;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Full operation: 4 busy cycles with outputs held, done on the 4th edge after start, then IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    launch(v.a, v.b, v.cin, v.sub);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s busy/done c%0d", tag, k), {bus.busy, bus.done}, 2'b10);
      chk($sformatf("%s sum hold c%0d", tag, k), bus.sum, prev_sum);
      tick();
    end
    chk({tag, " done"}, {bus.busy, bus.done}, 2'b01);
    chk({tag, " sum"},  bus.sum,  v.sum);
    chk({tag, " cout"}, bus.cout, v.cout);
    chk({tag, " ovf"},  bus.ovf,  v.ovf);
    prev_sum = v.sum;
    tick();
    chk({tag, " idle"}, {bus.busy, bus.done}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef CLA_SERIAL_SUB_EN
    bus.sub   = 1'b0;
`endif
    prev_sum  = 16'h0000;

    //              a        b        cin   sub   sum      cout  ovf
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h2468, 16'h1357, 1'b1, 1'b0, 16'h37C0, 1'b0, 1'b0});
`ifdef CLA_SERIAL_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy/done", {bus.busy, bus.done}, 2'b00);
    chk("reset sum",  bus.sum,  16'h0000);
    chk("reset cout", bus.cout, 1'b0);
    chk("reset ovf",  bus.ovf,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start during the 2nd RUN cycle must not disturb the operation in flight
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    tick();
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ignore busy", {bus.busy, bus.done}, 2'b10);
    tick();
    tick();
    chk("ignore done", {bus.busy, bus.done}, 2'b01);
    chk("ignore sum",  bus.sum,  16'h5555);
    chk("ignore cout", bus.cout, 1'b0);
    tick();
    chk("ignore idle", {bus.busy, bus.done}, 2'b00);

    // start held through DONE chains a second operation without an IDLE cycle
    @(negedge clk);
    bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.a = 16'h0010; bus.b = 16'h0020;
    repeat (4) tick();
    chk("b2b done1", {bus.busy, bus.done}, 2'b01);
    chk("b2b sum1",  bus.sum, 16'h0003);
    tick();
    bus.start = 1'b0;
    chk("b2b rerun", {bus.busy, bus.done}, 2'b10);
    chk("b2b hold",  bus.sum, 16'h0003);
    repeat (4) tick();
    chk("b2b done2", {bus.busy, bus.done}, 2'b01);
    chk("b2b sum2",  bus.sum, 16'h0030);
    tick();

    // asynchronous reset in the 3rd RUN cycle
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy/done", {bus.busy, bus.done}, 2'b00);
    chk("rst sum",  bus.sum,  16'h0000);
    chk("rst cout", bus.cout, 1'b0);
    chk("rst ovf",  bus.ovf,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.done || bus.busy) pulses++;
    end
    chk("rst no done", pulses, 0);
    prev_sum = 16'h0000;
    run_vec('{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0}, "post-rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
